// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 1-bit ALU slice ribbon: decodes slice controls,
// latches operands/controls, forwards from EX/MEM and MEM/WB, flags load-use stalls.
package id_ex_pkg;

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_ADD  = 3'b010,
    OP_XOR  = 3'b011,
    OP_SLL  = 3'b100,
    OP_SLT  = 3'b101,
    OP_MUL  = 3'b110,
    OP_LESS = 3'b111
  } slice_op_e;

  localparam logic [1:0] AOP_ADD = 2'b00;
  localparam logic [1:0] AOP_SUB = 2'b01;
  localparam logic [1:0] AOP_FN  = 2'b10;

endpackage

module id_ex_stage
  import id_ex_pkg::*;
#(
  parameter int WIDTH = 24,
  parameter int RADDR = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hold,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_rs_data,
  input  logic [WIDTH-1:0] in_rt_data,
  input  logic [WIDTH-1:0] in_imm,
  input  logic [RADDR-1:0] in_rs,
  input  logic [RADDR-1:0] in_rt,
  input  logic [RADDR-1:0] in_rd,
  input  logic             in_uses_rt,
  input  logic             in_alu_src,
  input  logic [1:0]       in_alu_op,
  input  logic [3:0]       in_funct,
  input  logic             in_reg_write,
  input  logic             in_mem_read,
  input  logic             in_mem_write,
  input  logic             in_mem_to_reg,
  input  logic             fwd_em_we,
  input  logic             fwd_mw_we,
  input  logic [RADDR-1:0] fwd_em_rd,
  input  logic [RADDR-1:0] fwd_mw_rd,
  input  logic [WIDTH-1:0] fwd_em_data,
  input  logic [WIDTH-1:0] fwd_mw_data,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_binvert,
  output logic             alu_cin,
  output logic [2:0]       alu_operation,
  output logic [WIDTH-1:0] ex_store_data,
  output logic             ex_valid,
  output logic [RADDR-1:0] ex_rd,
  output logic             ex_reg_write,
  output logic             ex_mem_read,
  output logic             ex_mem_write,
  output logic             ex_mem_to_reg,
  output logic             ex_illegal,
  output logic             load_use_stall
);

  typedef struct packed {
    logic             valid;
    logic [RADDR-1:0] rs;
    logic [RADDR-1:0] rt;
    logic [RADDR-1:0] rd;
    logic [WIDTH-1:0] rs_data;
    logic [WIDTH-1:0] rt_data;
    logic [WIDTH-1:0] imm;
    logic             alu_src;
    slice_op_e        op;
    logic             binvert;
    logic             cin;
    logic             illegal;
    logic             reg_write;
    logic             mem_read;
    logic             mem_write;
    logic             mem_to_reg;
  } id_ex_t;

  id_ex_t q;
  id_ex_t d;

  slice_op_e dec_op;
  logic      dec_inv;
  logic      dec_ill;

  always_comb begin
    dec_op  = OP_AND;
    dec_inv = 1'b0;
    dec_ill = 1'b0;
    unique case (in_alu_op)
      AOP_ADD: dec_op = OP_ADD;
      AOP_SUB: begin
        dec_op  = OP_ADD;
        dec_inv = 1'b1;
      end
      AOP_FN: begin
        case (in_funct)
          4'h0: dec_op = OP_ADD;
          4'h1: begin
            dec_op  = OP_ADD;
            dec_inv = 1'b1;
          end
          4'h2: dec_op = OP_AND;
          4'h3: dec_op = OP_OR;
          4'h4: dec_op = OP_XOR;
          4'h5: dec_op = OP_SLL;
          4'h6: begin
            dec_op  = OP_SLT;
            dec_inv = 1'b1;
          end
          4'h7: dec_op = OP_MUL;
          default: dec_ill = 1'b1;
        endcase
      end
      default: dec_ill = 1'b1;
    endcase
  end

  always_comb begin
    d            = '0;
    d.valid      = in_valid;
    d.rs         = in_rs;
    d.rt         = in_rt;
    d.rd         = in_rd;
    d.rs_data    = in_rs_data;
    d.rt_data    = in_rt_data;
    d.imm        = in_imm;
    d.alu_src    = in_alu_src;
    d.op         = dec_op;
    d.binvert    = dec_inv;
    d.cin        = dec_inv;
    d.illegal    = dec_ill;
    d.reg_write  = in_reg_write;
    d.mem_read   = in_mem_read;
    d.mem_write  = in_mem_write;
    d.mem_to_reg = in_mem_to_reg;
  end

  logic hit_rs;
  logic hit_rt;

  always_comb begin
    hit_rs = (q.rd == in_rs);
    hit_rt = in_uses_rt & (q.rd == in_rt);
    load_use_stall = ~hold & q.valid & q.mem_read
                   & (q.rd != '0) & in_valid
                   & (hit_rs | hit_rt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (flush) begin
      q <= '0;
    end else if (hold) begin
      q <= q;
    end else if (load_use_stall) begin
      q <= '0;
    end else begin
      q <= d;
    end
  end

  logic [WIDTH-1:0] fwd_rs;
  logic [WIDTH-1:0] fwd_rt;

  // r0 never forwards so it always reads the latched zero
  always_comb begin
    fwd_rs = q.rs_data;
    if (q.rs != '0) begin
      if (fwd_em_we && fwd_em_rd == q.rs) begin
        fwd_rs = fwd_em_data;
      end else if (fwd_mw_we && fwd_mw_rd == q.rs) begin
        fwd_rs = fwd_mw_data;
      end
    end
  end

  always_comb begin
    fwd_rt = q.rt_data;
    if (q.rt != '0) begin
      if (fwd_em_we && fwd_em_rd == q.rt) begin
        fwd_rt = fwd_em_data;
      end else if (fwd_mw_we && fwd_mw_rd == q.rt) begin
        fwd_rt = fwd_mw_data;
      end
    end
  end

  assign alu_a         = fwd_rs;
  assign alu_b         = q.alu_src ? q.imm : fwd_rt;
  assign ex_store_data = fwd_rt;
  assign alu_binvert   = q.binvert;
  assign alu_cin       = q.cin;
  assign alu_operation = q.op;
  assign ex_valid      = q.valid;
  assign ex_rd         = q.rd;
  assign ex_reg_write  = q.reg_write;
  assign ex_mem_read   = q.mem_read;
  assign ex_mem_write  = q.mem_write;
  assign ex_mem_to_reg = q.mem_to_reg;
  assign ex_illegal    = q.illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios plus randomized traffic
// checked against a behavioural model of the stage.
module tb_id_ex_stage;

  logic        clk;
  logic        rst_n;
  logic        hold;
  logic        flush;
  logic        in_valid;
  logic [23:0] in_rs_data;
  logic [23:0] in_rt_data;
  logic [23:0] in_imm;
  logic [3:0]  in_rs;
  logic [3:0]  in_rt;
  logic [3:0]  in_rd;
  logic        in_uses_rt;
  logic        in_alu_src;
  logic [1:0]  in_alu_op;
  logic [3:0]  in_funct;
  logic        in_reg_write;
  logic        in_mem_read;
  logic        in_mem_write;
  logic        in_mem_to_reg;
  logic        fwd_em_we;
  logic        fwd_mw_we;
  logic [3:0]  fwd_em_rd;
  logic [3:0]  fwd_mw_rd;
  logic [23:0] fwd_em_data;
  logic [23:0] fwd_mw_data;
  logic [23:0] alu_a;
  logic [23:0] alu_b;
  logic        alu_binvert;
  logic        alu_cin;
  logic [2:0]  alu_operation;
  logic [23:0] ex_store_data;
  logic        ex_valid;
  logic [3:0]  ex_rd;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        ex_mem_to_reg;
  logic        ex_illegal;
  logic        load_use_stall;

  int n_tests;
  int n_fail;

  id_ex_stage #(.WIDTH(24), .RADDR(4)) dut (
    .clk(clk), .rst_n(rst_n), .hold(hold), .flush(flush),
    .in_valid(in_valid), .in_rs_data(in_rs_data),
    .in_rt_data(in_rt_data), .in_imm(in_imm),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_uses_rt(in_uses_rt), .in_alu_src(in_alu_src),
    .in_alu_op(in_alu_op), .in_funct(in_funct),
    .in_reg_write(in_reg_write), .in_mem_read(in_mem_read),
    .in_mem_write(in_mem_write), .in_mem_to_reg(in_mem_to_reg),
    .fwd_em_we(fwd_em_we), .fwd_mw_we(fwd_mw_we),
    .fwd_em_rd(fwd_em_rd), .fwd_mw_rd(fwd_mw_rd),
    .fwd_em_data(fwd_em_data), .fwd_mw_data(fwd_mw_data),
    .alu_a(alu_a), .alu_b(alu_b),
    .alu_binvert(alu_binvert), .alu_cin(alu_cin),
    .alu_operation(alu_operation),
    .ex_store_data(ex_store_data), .ex_valid(ex_valid),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_illegal(ex_illegal),
    .load_use_stall(load_use_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wire [87:0] dut_vec = {alu_a, alu_b, alu_binvert, alu_cin,
    alu_operation, ex_store_data, ex_valid, ex_rd,
    ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
    ex_illegal, load_use_stall};

  // model of the instruction sitting in EX
  logic        m_valid;
  logic [3:0]  m_rs, m_rt, m_rd;
  logic [23:0] m_rsd, m_rtd, m_imm;
  logic        m_src;
  logic [5:0]  m_dec;
  logic [3:0]  m_ctl;

  // {operation, binvert, cin, illegal}
  function automatic logic [5:0] dec_model(
    input logic [1:0] aop, input logic [3:0] f);
    int opt [8] = '{2, 2, 0, 1, 3, 4, 5, 6};
    logic sub;
    if (aop == 2'd0) return 6'b010_0_0_0;
    if (aop == 2'd1) return 6'b010_1_1_0;
    if (aop == 2'd3 || f > 4'd7) return 6'b000_0_0_1;
    sub = (f == 4'd1) || (f == 4'd6);
    return {opt[f][2:0], sub, sub, 1'b0};
  endfunction

  function automatic logic [23:0] fwd_m(
    input logic [3:0] r, input logic [23:0] v);
    if (r == 4'd0) return v;
    if (fwd_em_we && fwd_em_rd == r) return fwd_em_data;
    if (fwd_mw_we && fwd_mw_rd == r) return fwd_mw_data;
    return v;
  endfunction

  function automatic logic stall_m();
    if (hold || !m_valid || !m_ctl[2] || m_rd == 4'd0) return 1'b0;
    if (!in_valid) return 1'b0;
    return (m_rd == in_rs) || (in_uses_rt && m_rd == in_rt);
  endfunction

  function automatic logic [87:0] exp_vec();
    logic [23:0] a, t;
    a = fwd_m(m_rs, m_rsd);
    t = fwd_m(m_rt, m_rtd);
    return {a, (m_src ? m_imm : t), m_dec[2], m_dec[1],
      m_dec[5:3], t, m_valid, m_rd, m_ctl, m_dec[0], stall_m()};
  endfunction

  task automatic clear_model();
    m_valid = 0; m_rs = 0; m_rt = 0; m_rd = 0;
    m_rsd = 0; m_rtd = 0; m_imm = 0; m_src = 0;
    m_dec = 0; m_ctl = 0;
  endtask

  task automatic tick();
    logic st;
    st = stall_m();
    @(posedge clk);
    if (!rst_n || flush) begin
      clear_model();
    end else if (hold) begin
    end else if (st) begin
      clear_model();
    end else begin
      m_valid = in_valid; m_rs = in_rs; m_rt = in_rt;
      m_rd = in_rd; m_rsd = in_rs_data; m_rtd = in_rt_data;
      m_imm = in_imm; m_src = in_alu_src;
      m_dec = dec_model(in_alu_op, in_funct);
      m_ctl = {in_reg_write, in_mem_read, in_mem_write,
               in_mem_to_reg};
    end
    #1;
  endtask

  task automatic set_instr(input logic [3:0] rs, input logic [3:0] rt,
    input logic [3:0] rd, input logic [23:0] rsd,
    input logic [23:0] rtd, input logic [1:0] aop,
    input logic [3:0] f);
    in_valid = 1; in_rs = rs; in_rt = rt; in_rd = rd;
    in_rs_data = rsd; in_rt_data = rtd; in_imm = 24'h000010;
    in_alu_src = 0; in_uses_rt = 1; in_alu_op = aop;
    in_funct = f; in_reg_write = 1; in_mem_read = 0;
    in_mem_write = 0; in_mem_to_reg = 0;
  endtask

  task automatic quiet_fwd();
    fwd_em_we = 0; fwd_mw_we = 0; fwd_em_rd = 0; fwd_mw_rd = 0;
    fwd_em_data = 0; fwd_mw_data = 0;
  endtask

  task automatic randomize_inputs();
    in_valid = 1'($urandom); in_rs = 4'($urandom_range(0, 3));
    in_rt = 4'($urandom_range(0, 3));
    in_rd = 4'($urandom_range(0, 3));
    in_rs_data = 24'($urandom); in_rt_data = 24'($urandom);
    in_imm = 24'($urandom); in_uses_rt = 1'($urandom);
    in_alu_src = 1'($urandom); in_alu_op = 2'($urandom);
    in_funct = 4'($urandom); in_reg_write = 1'($urandom);
    in_mem_read = 1'($urandom); in_mem_write = 1'($urandom);
    in_mem_to_reg = 1'($urandom);
  endtask

  task automatic test_reset();
    {hold, flush, in_valid, in_uses_rt, in_alu_src} = '1;
    {in_rs_data, in_rt_data, in_imm} = '1;
    {in_rs, in_rt, in_rd, in_alu_op, in_funct} = '1;
    {in_reg_write, in_mem_read, in_mem_write, in_mem_to_reg} = '1;
    {fwd_em_we, fwd_mw_we, fwd_em_rd, fwd_mw_rd} = '1;
    {fwd_em_data, fwd_mw_data} = '1;
    rst_n = 0;
    clear_model();
    @(posedge clk); @(posedge clk); #1;
    n_tests++;
    if (dut_vec !== 88'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %h want 0", dut_vec);
    end
    hold = 0; flush = 0; quiet_fwd();
    set_instr(4'd1, 4'd2, 4'd3, 24'd1, 24'd2, 2'b10, 4'h0);
    rst_n = 1;
    tick();
    n_tests++;
    if ({alu_a, alu_b, alu_operation, alu_binvert, alu_cin, ex_valid}
        !== {24'd1, 24'd2, 3'b010, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL add_r3: got a=%h b=%h op=%b inv=%b cin=%b v=%b",
        alu_a, alu_b, alu_operation, alu_binvert, alu_cin, ex_valid);
    end
  endtask

  task automatic test_funct();
    set_instr(4'd5, 4'd7, 4'd8, 24'd3, 24'd4, 2'b10, 4'h6);
    tick();
    n_tests++;
    if ({alu_operation, alu_binvert, alu_cin, ex_illegal}
        !== 6'b101_1_1_0) begin
      n_fail++;
      $display("FAIL slt_decode: got op=%b inv=%b cin=%b ill=%b want 101 1 1 0",
        alu_operation, alu_binvert, alu_cin, ex_illegal);
    end
    in_funct = 4'hA;
    tick();
    n_tests++;
    if ({alu_operation, ex_illegal} !== 4'b000_1) begin
      n_fail++;
      $display("FAIL illegal_funct: got op=%b ill=%b want 000 1",
        alu_operation, ex_illegal);
    end
    for (int i = 0; i < 48; i++) begin
      in_alu_op = 2'($urandom);
      in_funct = (i < 16) ? 4'(i) : 4'($urandom);
      if (i < 16) in_alu_op = 2'b10;
      tick();
      n_tests++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL decode aop=%b f=%h: got %h want %h",
          in_alu_op, in_funct, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_forward();
    set_instr(4'd4, 4'd4, 4'd9, 24'h000111, 24'h000222, 2'b00, 4'h0);
    tick();
    fwd_em_we = 1; fwd_em_rd = 4'd4; fwd_em_data = 24'hABCDEF;
    fwd_mw_we = 1; fwd_mw_rd = 4'd4; fwd_mw_data = 24'h000001;
    #1;
    n_tests++;
    if ({alu_a, ex_store_data} !== {24'hABCDEF, 24'hABCDEF}) begin
      n_fail++;
      $display("FAIL fwd_em_wins: got a=%h sd=%h want abcdef",
        alu_a, ex_store_data);
    end
    fwd_em_we = 0; #1;
    n_tests++;
    if (alu_a !== 24'h000001) begin
      n_fail++;
      $display("FAIL fwd_mw: got %h want 000001", alu_a);
    end
    quiet_fwd();
    set_instr(4'd0, 4'd0, 4'd9, 24'd0, 24'd0, 2'b00, 4'h0);
    tick();
    fwd_em_we = 1; fwd_em_rd = 4'd0; fwd_em_data = 24'h123456;
    fwd_mw_we = 1; fwd_mw_rd = 4'd0; fwd_mw_data = 24'h654321;
    #1;
    n_tests++;
    if ({alu_a, alu_b} !== 48'd0) begin
      n_fail++;
      $display("FAIL fwd_r0: got a=%h b=%h want 0", alu_a, alu_b);
    end
    for (int i = 0; i < 40; i++) begin
      randomize_inputs();
      in_mem_read = 0;
      tick();
      fwd_em_we = 1'($urandom); fwd_mw_we = 1'($urandom);
      fwd_em_rd = 4'($urandom_range(0, 3));
      fwd_mw_rd = 4'($urandom_range(0, 3));
      fwd_em_data = 24'($urandom); fwd_mw_data = 24'($urandom);
      #1;
      n_tests++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL fwd_rand %0d: got %h want %h", i, dut_vec, exp_vec());
      end
    end
    quiet_fwd();
  endtask

  task automatic test_load_use();
    set_instr(4'd1, 4'd2, 4'd6, 24'd5, 24'd6, 2'b00, 4'h0);
    in_mem_read = 1; in_mem_to_reg = 1;
    tick();
    set_instr(4'd1, 4'd6, 4'd7, 24'd8, 24'd0, 2'b10, 4'h0);
    #1;
    n_tests++;
    if (load_use_stall !== 1'b1) begin
      n_fail++;
      $display("FAIL load_use_raise: got %b want 1", load_use_stall);
    end
    tick();
    n_tests++;
    if ({ex_valid, ex_reg_write, ex_mem_read, ex_mem_to_reg,
         alu_operation, load_use_stall} !== 8'd0) begin
      n_fail++;
      $display("FAIL load_use_bubble: got v=%b ctl=%b%b%b op=%b st=%b want 0",
        ex_valid, ex_reg_write, ex_mem_read, ex_mem_to_reg,
        alu_operation, load_use_stall);
    end
    fwd_mw_we = 1; fwd_mw_rd = 4'd6; fwd_mw_data = 24'h0BEEF0;
    tick();
    n_tests++;
    if ({ex_valid, ex_rd, alu_b} !== {1'b1, 4'd7, 24'h0BEEF0}) begin
      n_fail++;
      $display("FAIL load_use_dep: got v=%b rd=%0d b=%h want 1 7 0beef0",
        ex_valid, ex_rd, alu_b);
    end
    quiet_fwd();
  endtask

  task automatic test_hold();
    set_instr(4'd2, 4'd3, 4'd11, 24'h00AAAA, 24'h005555, 2'b01, 4'h0);
    tick();
    hold = 1;
    for (int i = 0; i < 3; i++) begin
      randomize_inputs();
      tick();
      n_tests++;
      if (dut_vec !== exp_vec() || ex_rd !== 4'd11) begin
        n_fail++;
        $display("FAIL hold_%0d: got %h want %h", i, dut_vec, exp_vec());
      end
    end
    flush = 1;
    tick();
    n_tests++;
    if ({ex_valid, ex_rd, ex_reg_write, alu_operation} !== 9'd0) begin
      n_fail++;
      $display("FAIL flush_hold: got v=%b rd=%0d rw=%b op=%b want 0",
        ex_valid, ex_rd, ex_reg_write, alu_operation);
    end
    hold = 0; flush = 0;
  endtask

  task automatic test_async_reset();
    set_instr(4'd1, 4'd2, 4'd5, 24'd9, 24'd9, 2'b10, 4'h6);
    tick();
    n_tests++;
    if (ex_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_valid: got %b want 1", ex_valid);
    end
    #2;
    rst_n = 0;
    #1;
    clear_model();
    n_tests++;
    if ({ex_valid, ex_rd, alu_operation, alu_binvert, ex_reg_write}
        !== 10'd0 || clk !== 1'b1) begin
      n_fail++;
      $display("FAIL async_reset: got v=%b rd=%0d op=%b inv=%b want 0",
        ex_valid, ex_rd, alu_operation, alu_binvert);
    end
    #1;
    rst_n = 1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      randomize_inputs();
      hold = ($urandom_range(0, 7) == 0);
      flush = ($urandom_range(0, 9) == 0);
      fwd_em_we = 1'($urandom); fwd_mw_we = 1'($urandom);
      fwd_em_rd = 4'($urandom_range(0, 3));
      fwd_mw_rd = 4'($urandom_range(0, 3));
      fwd_em_data = 24'($urandom); fwd_mw_data = 24'($urandom);
      #1;
      n_tests++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL random %0d: got %h want %h", i, dut_vec, exp_vec());
      end
      tick();
    end
    hold = 0; flush = 0;
  endtask

  initial begin
    n_tests = 0;
    n_fail = 0;
    test_reset();
    test_funct();
    test_forward();
    test_load_use();
    test_hold();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
